fb_arbiter: RTL and testbench
=============================

Name: fb_arbiter

Overview:
- Shares the single-port 8 KiB framebuffer RAM between two requesters:
  - the OLED controller's display read port (pixel_re/pixel_addr/pixel_data), which cannot stall;
  - a CPU bus port with a req/ack handshake.
- The display port has priority but is fetch-on-change, so the CPU uses the idle RAM cycles. A starvation guard bounds CPU wait.
- Sits between oled, the CPU bus decoder and the framebuffer RAM instance.

Parameters:
- ADDR_WIDTH, 13, framebuffer byte address width (8192 bytes).
- DATA_WIDTH, 8, framebuffer data width.
- MAX_WAIT, 4, max consecutive cycles a pending CPU request is denied before it is forcibly granted (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- pixel_re  in  1  display read enable
- pixel_addr  in  ADDR_WIDTH  display read address
- pixel_data  out  DATA_WIDTH  display read data
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_ack  out  1  combinational; high in the cycle the CPU access is issued to RAM
- cpu_rvalid  out  1  registered; high 1 cycle after a read ack
- cpu_rdata  out  DATA_WIDTH  read data, valid with cpu_rvalid
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_q  in  DATA_WIDTH  RAM read data; synchronous, 1-cycle latency

Behaviour:
- Internal state:
  - fetched_addr/fetched_valid: address currently held for the display.
  - disp_inflight: display read issued last cycle.
  - cpu_rd_inflight: CPU read issued last cycle.
  - hold_q: captured display data.
  - wait_cnt: saturating CPU-denial counter, 0..MAX_WAIT.
- Reset (async): all outputs 0, hold_q 0, fetched_valid 0, both inflight flags 0, wait_cnt 0.
- disp_need = pixel_re && !(fetched_valid && pixel_addr == fetched_addr).
- Per-cycle arbitration, exactly one grant or none:
  - If disp_need && !(cpu_req && wait_cnt == MAX_WAIT): DISPLAY grant.
    - ram_addr = pixel_addr, ram_we = 0.
    - Next cycle: fetched_addr <= pixel_addr, fetched_valid <= 1, disp_inflight <= 1.
  - Else if cpu_req: CPU grant.
    - ram_addr = cpu_addr, ram_we = cpu_we, ram_wdata = cpu_wdata, cpu_ack = 1.
    - wait_cnt <= 0; cpu_rd_inflight <= !cpu_we.
  - Else: idle. ram_we = 0, ram_addr = pixel_addr.
- wait_cnt increments, saturating at MAX_WAIT, in every cycle cpu_req is high and not acked.
- Display data:
  - pixel_data = ram_q when disp_inflight, else hold_q.
  - hold_q <= ram_q when disp_inflight.
  - Uncontended latency is 1 cycle after an address change, same as a plain synchronous RAM.
  - Latency is 2 cycles when the starvation guard fires.
- CPU reads: cpu_rvalid = cpu_rd_inflight, cpu_rdata = ram_q in that cycle. Writes produce no rvalid.
- Coherence:
  - A CPU write granted to an address equal to fetched_addr clears fetched_valid, forcing a display refetch.
  - The refetch is issued next cycle; the write is visible in RAM by then.
- pixel_re low clears fetched_valid next cycle, so re-enable always refetches.
- Simultaneous DISPLAY grant and CPU write to the same address cannot occur (single port).
- A display address change during the disp_inflight cycle is a new disp_need, granted that cycle (back-to-back fetches allowed).
- cpu_req dropped before ack: no access; wait_cnt <= 0.
- Reset mid-access: the in-flight read result is discarded, no cpu_rvalid; the display refetches after reset.

Test Plan:
1. Display only: pixel_re = 1, pixel_addr stepping 0,0,1,1,2,2, RAM preloaded with mem[a] = a ^ 8'h5A.
   - Required: a single RAM read per address.
   - Required: pixel_data = 8'h5A, 8'h5B, 8'h58, each valid 1 cycle after its address change.
2. CPU only: write 8'hC3 to 13'h0100, then read 13'h0100.
   - Required: cpu_ack each in its request cycle.
   - Required: cpu_rvalid 1 cycle after the read ack with cpu_rdata = 8'hC3.
3. Interleave: display address changes every 2 cycles while cpu_req is held continuously.
   - Required: CPU acked in every non-fetch cycle.
   - Required: display data latency always 1; wait_cnt never reaches MAX_WAIT.
4. Starvation: MAX_WAIT = 4, display address changes every cycle, cpu_req held.
   - Required: CPU denied 4 cycles, acked on the 5th.
   - Required: the display fetch for that cycle is issued next cycle and its data is 2 cycles late.
5. Coherence: display holding addr 13'h0040 (mem = 8'h11), CPU writes 8'h99 to 13'h0040.
   - Required: refetch the next cycle; pixel_data = 8'h99 two cycles after the write ack.
6. Async reset asserted the cycle after a CPU read ack.
   - Required: no cpu_rvalid, all outputs 0 immediately.
   - Required: after release with pixel_re = 1, a fresh display fetch on the first cycle.

Source files
------------

// File: rtl/fb_arbiter.sv
// Framebuffer single-port RAM arbiter: the display read port is fetch-on-change
// with priority, and the CPU req/ack port uses idle RAM cycles with a bounded wait.
module fb_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pixel_re,
  input  logic [ADDR_WIDTH-1:0] pixel_addr,
  output logic [DATA_WIDTH-1:0] pixel_data,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT);

  logic [ADDR_WIDTH-1:0] fetched_addr_q, fetched_addr_d;
  logic                  fetched_valid_q, fetched_valid_d;
  logic                  disp_inflight_q, disp_inflight_d;
  logic                  cpu_rd_inflight_q, cpu_rd_inflight_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;

  logic disp_need;
  logic starving;
  logic grant_disp;
  logic grant_cpu;

  always_comb begin
    disp_need  = pixel_re && !(fetched_valid_q && (pixel_addr == fetched_addr_q));
    starving   = cpu_req && (wait_cnt_q == WAIT_SAT);
    grant_disp = disp_need && !starving;
    grant_cpu  = cpu_req && !grant_disp;
  end

  // Combinational outputs are forced low while reset is asserted.
  always_comb begin
    cpu_ack   = rst_n && grant_cpu;
    ram_we    = rst_n && grant_cpu && cpu_we;
    ram_addr  = '0;
    ram_wdata = '0;
    if (rst_n) begin
      ram_addr = grant_cpu ? cpu_addr : pixel_addr;
      if (grant_cpu) begin
        ram_wdata = cpu_wdata;
      end
    end
  end

  assign pixel_data = disp_inflight_q ? ram_q : hold_q;
  assign cpu_rvalid = cpu_rd_inflight_q;
  assign cpu_rdata  = cpu_rd_inflight_q ? ram_q : '0;

  always_comb begin
    fetched_addr_d    = fetched_addr_q;
    fetched_valid_d   = fetched_valid_q;
    disp_inflight_d   = grant_disp;
    cpu_rd_inflight_d = grant_cpu && !cpu_we;
    hold_d            = disp_inflight_q ? ram_q : hold_q;
    wait_cnt_d        = '0;

    if (grant_disp) begin
      fetched_addr_d  = pixel_addr;
      fetched_valid_d = 1'b1;
    end
    // A CPU write over the displayed byte forces a refetch next cycle.
    if (grant_cpu && cpu_we && fetched_valid_q && (cpu_addr == fetched_addr_q)) begin
      fetched_valid_d = 1'b0;
    end
    if (!pixel_re) begin
      fetched_valid_d = 1'b0;
    end

    if (cpu_req && !grant_cpu) begin
      wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_addr_q    <= '0;
      fetched_valid_q   <= 1'b0;
      disp_inflight_q   <= 1'b0;
      cpu_rd_inflight_q <= 1'b0;
      hold_q            <= '0;
      wait_cnt_q        <= '0;
    end else begin
      fetched_addr_q    <= fetched_addr_d;
      fetched_valid_q   <= fetched_valid_d;
      disp_inflight_q   <= disp_inflight_d;
      cpu_rd_inflight_q <= cpu_rd_inflight_d;
      hold_q            <= hold_d;
      wait_cnt_q        <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios plus a random phase, checked against a
// cycle-level reference model with a shadow memory and expectation queues.
module tb_fb_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pixel_re;
  logic [AW-1:0] pixel_addr;
  logic [DW-1:0] pixel_data;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_q;

  always #5 clk = ~clk;

  fb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pixel_re(pixel_re), .pixel_addr(pixel_addr), .pixel_data(pixel_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port RAM, 1-cycle read latency, read-first.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          preload_req, bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (bd_we)  mem[bd_addr]  <= bd_data;
    end
    ram_q <= mem[ram_addr];
  end

  // Reference model: decides who owns the RAM each cycle from the arbitration
  // rules and predicts what each requester must see, using a shadow memory.
  typedef struct { int due; logic [DW-1:0] val; } exp_t;
  exp_t disp_q[$];
  exp_t rd_q[$];

  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic          model_en;
  logic          m_fv;
  logic [AW-1:0] m_fa;
  int            m_wait;

  always @(negedge clk) begin : model
    logic need, g_disp, g_cpu;
    if (preload_req) for (int i = 0; i < (1 << AW); i++) shadow[i] = 8'(i) ^ 8'h5A;
    if (bd_we) shadow[bd_addr] = bd_data;
    if (!model_en) begin
      m_fv = 1'b0; m_fa = '0; m_wait = 0;
      disp_q.delete(); rd_q.delete();
    end else begin
      need   = pixel_re && !(m_fv && pixel_addr == m_fa);
      g_disp = need && !(cpu_req && m_wait >= MW);
      g_cpu  = cpu_req && !g_disp;
      chk("ack", 32'(cpu_ack), 32'(g_cpu));
      chk("ram_we", 32'(ram_we), 32'(g_cpu && cpu_we));
      chk("ram_addr", 32'(ram_addr), 32'(g_cpu ? cpu_addr : pixel_addr));
      if (g_cpu && cpu_we) chk("ram_wdata", 32'(ram_wdata), 32'(cpu_wdata));
      if (g_disp) disp_q.push_back('{due: cyc + 1, val: shadow[pixel_addr]});
      if (g_cpu && !cpu_we) rd_q.push_back('{due: cyc + 1, val: shadow[cpu_addr]});
      if (g_cpu && cpu_we) begin
        shadow[cpu_addr] = cpu_wdata;
        if (m_fv && cpu_addr == m_fa) m_fv = 1'b0;
      end
      m_wait = (cpu_req && !g_cpu) ? ((m_wait + 1 > MW) ? MW : m_wait + 1) : 0;
      if (g_disp) begin m_fa = pixel_addr; m_fv = 1'b1; end
      if (!pixel_re) m_fv = 1'b0;
    end
  end

  // Monitor: consumes expectations as the DUT presents display and read data.
  logic [DW-1:0] m_hold;
  always @(negedge clk) begin : monitor
    logic [DW-1:0] exp_pix;
    if (!model_en) begin
      m_hold = '0;
    end else begin
      exp_pix = m_hold;
      if (disp_q.size() > 0 && disp_q[0].due == cyc) begin
        exp_pix = disp_q[0].val;
        m_hold  = exp_pix;
        void'(disp_q.pop_front());
      end
      chk("pixel_data", 32'(pixel_data), 32'(exp_pix));
      if (cpu_rvalid) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_rvalid", 32'(cpu_rvalid), 32'd0);
        end else begin
          chk("rvalid_cycle", 32'(cyc), 32'(rd_q[0].due));
          chk("cpu_rdata", 32'(cpu_rdata), 32'(rd_q[0].val));
          void'(rd_q.pop_front());
        end
      end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        chk("missing_rvalid", 32'(cpu_rvalid), 32'd1);
        void'(rd_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pixel_data"}, 32'(pixel_data), 32'd0);
    chk({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
    chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int deny, max_deny, acks, got, a4;
    logic acked, pend;
    rst_n = 1'b0; model_en = 1'b0; preload_req = 1'b1;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    pixel_re = 1'b0; pixel_addr = 13'h155;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0AA; cpu_wdata = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    preload_req = 1'b0;
    cpu_req = 1'b0; pixel_re = 1'b0;
    rst_n = 1'b1; model_en = 1'b1;
    step();

    // Display only: two cycles per address.
    pixel_re = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pixel_addr = AW'(k / 2);
      @(negedge clk);
      if (k % 2 == 1) chk("t1_pixel", 32'(pixel_data), 32'((k / 2) ^ 'h5A));
      step();
    end

    // CPU write then read-back.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0100; cpu_wdata = 8'hC3;
    @(negedge clk); chk("t2_wr_ack", 32'(cpu_ack), 32'd1); step();
    cpu_we = 1'b0;
    @(negedge clk); chk("t2_rd_ack", 32'(cpu_ack), 32'd1); step();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("t2_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("t2_rdata", 32'(cpu_rdata), 32'hC3);
    step();

    // Interleave: display change every 2 cycles, CPU continuously requesting.
    deny = 0; max_deny = 0; acks = 0;
    cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
    cpu_addr = AW'(13'h200 + $urandom_range(0, 15)); cpu_wdata = 8'($urandom_range(0, 255));
    for (int i = 0; i < 40; i++) begin
      pixel_addr = AW'(16 + i / 2);
      @(negedge clk);
      acked = cpu_ack;
      chk("t3_ack", 32'(acked), 32'(i % 2));
      if (i % 2 == 1) chk("t3_pixel", 32'(pixel_data), 32'(8'(16 + i / 2) ^ 8'h5A));
      if (acked) begin acks++; deny = 0; end
      else begin deny++; if (deny > max_deny) max_deny = deny; end
      step();
      if (acked) begin
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'(13'h200 + $urandom_range(0, 15));
        cpu_wdata = 8'($urandom_range(0, 255));
      end
    end
    chk("t3_max_deny_below_limit", 32'(max_deny < MW), 32'd1);
    chk("t3_ack_count", 32'(acks), 32'd20);
    cpu_req = 1'b0;
    step();

    // Starvation: display address changes every cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0100;
    deny = 0; got = 0; a4 = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      a4 = 'h300 + i;
      pixel_addr = AW'(a4);
      @(negedge clk);
      if (cpu_ack) got = 1; else deny++;
      step();
    end
    chk("t4_acked", 32'(got), 32'd1);
    chk("t4_denials", 32'(deny), 32'(MW));
    cpu_req = 1'b0;
    @(negedge clk);
    chk("t4_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("t4_rdata", 32'(cpu_rdata), 32'hC3);
    step();
    @(negedge clk);
    chk("t4_pixel_late", 32'(pixel_data), 32'(8'(a4) ^ 8'h5A));
    step();

    // Coherence: CPU overwrites the byte currently displayed.
    bd_we = 1'b1; bd_addr = 13'h0040; bd_data = 8'h11;
    step();
    bd_we = 1'b0;
    pixel_addr = 13'h0040;
    repeat (2) step();
    @(negedge clk); chk("t5_pixel_before", 32'(pixel_data), 32'h11); step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0040; cpu_wdata = 8'h99;
    @(negedge clk); chk("t5_wr_ack", 32'(cpu_ack), 32'd1); step();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("t5_refetch_addr", 32'(ram_addr), 32'h40);
    chk("t5_pixel_stale", 32'(pixel_data), 32'h11);
    step();
    @(negedge clk); chk("t5_pixel_new", 32'(pixel_data), 32'h99); step();

    // Reset in the cycle after a CPU read ack.
    pixel_addr = 13'h0007;
    repeat (2) step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0100;
    @(negedge clk); chk("t6_rd_ack", 32'(cpu_ack), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; model_en = 1'b0;
    #1;
    chk_all_zero("t6_reset");
    @(negedge clk); chk("t6_no_rvalid", 32'(cpu_rvalid), 32'd0);
    step();
    cpu_req = 1'b0; rst_n = 1'b1; model_en = 1'b1;
    @(negedge clk);
    chk("t6_fetch_addr", 32'(ram_addr), 32'h7);
    chk("t6_fetch_we", 32'(ram_we), 32'd0);
    step();
    @(negedge clk); chk("t6_fetch_data", 32'(pixel_data), 32'h5D); step();

    // Random traffic over a small shared address window.
    pend = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) pixel_addr = AW'($urandom_range(0, 7));
      pixel_re = ($urandom_range(0, 9) != 0);
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1'b1; cpu_req = 1'b1;
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom_range(0, 7));
        cpu_wdata = 8'($urandom_range(0, 255));
      end else if (pend && $urandom_range(0, 19) == 0) begin
        pend = 1'b0; cpu_req = 1'b0;
      end
      @(negedge clk);
      acked = cpu_ack;
      step();
      if (acked) begin pend = 1'b0; cpu_req = 1'b0; end
    end
    cpu_req = 1'b0;
    repeat (4) step();
    chk("end_rd_queue_empty", 32'(rd_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
